pito_rv32_mc_core: RTL and testbench
====================================

Name: pito_rv32_mc_core

Overview:
- Single-hart, multi-cycle RV32I integer core with separate instruction and data memory ports and a minimal read-only CSR set.
- Used as the processor under test in the core/CSR verification environment.
- The bench loads a program into memory and checks architectural results through memory contents, the retire pulse, the halt flag and the debug PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HART_ID, 0, value returned by the mhartid CSR.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address of the instruction fetch (= PC).
- imem_rd  out  1  fetch strobe; imem_rdata is valid the following cycle.
- imem_rdata  in  32  instruction word.
- dmem_addr  out  32  word-aligned data address (low 2 bits forced to 0).
- dmem_rd  out  1  load strobe; dmem_rdata is valid the following cycle.
- dmem_wr  out  1  store strobe; write occurs at that clock edge.
- dmem_be  out  4  byte enables for stores.
- dmem_wdata  out  32  store data, already lane-shifted.
- dmem_rdata  in  32  load data word.
- retire  out  1  one-cycle pulse per retired instruction.
- halted  out  1  high once the core has halted; stays high until reset.
- pc_out  out  32  current PC (debug).

Behaviour:
- Reset (asynchronous):
  - PC = RESET_PC, state = FETCH.
  - All x registers = 0; mcycle = 0; minstret = 0.
  - All strobes, retire and halted = 0; dmem_be = 0.
- FSM states and transitions:
  - FETCH: imem_rd=1, imem_addr=PC -> DECODE.
  - DECODE: latch imem_rdata as instr; read rs1/rs2 -> EXEC.
  - EXEC: perform the ALU/branch/CSR operation.
    - For non-memory instructions: write rd, update PC, retire=1 -> FETCH.
    - For loads/stores -> MEM.
  - MEM:
    - Store: dmem_wr=1, dmem_be and dmem_wdata driven; PC+=4; retire=1 -> FETCH.
    - Load: dmem_rd=1 -> LOADWB.
  - LOADWB: extract the byte/half/word from dmem_rdata using addr[1:0], sign- or zero-extend, write rd, PC+=4, retire=1 -> FETCH.
  - HALT: no strobes, halted=1; remains until rst.
- Latency (cycles per instruction): ALU/branch/jump/CSR 3, store 4, load 5.
- x0 always reads 0; writes to x0 are discarded.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU, SB, SH, SW.
  - All OP-IMM and OP ALU instructions. Shifts use the low 5 bits of the amount; SRA/SRAI are arithmetic.
  - FENCE: executes as a NOP.
- Branch/jump target = PC + sign-extended immediate; all arithmetic is modulo 2^32.
- JAL/JALR write PC+4 to rd.
- Misaligned access:
  - dmem_addr = {addr[31:2], 2'b00}; addr[1:0] selects the byte lane.
  - Halfword with addr[0]=1 uses lanes [2:1] unchanged (no trap).
  - Misaligned branch/jump targets are not trapped; the PC is taken as computed.
- Store lanes:
  - SB: be = 1 << addr[1:0], data byte replicated on all lanes.
  - SH: be = 4'b0011 or 4'b1100 per addr[1], data halfword replicated.
  - SW: be = 4'b1111.
- CSR:
  - CSRRW/CSRRS/CSRRC and their immediate forms read the CSR into rd.
  - All writes are ignored (read-only set).
  - Readable CSRs:
    - 0xB00 / 0xC00 mcycle/cycle: cycles since reset, +1 every clock except while in reset.
    - 0xB02 / 0xC02 minstret/instret: count of retire pulses.
    - 0xF14 mhartid: HART_ID.
  - An unknown CSR address reads as 0.
- ECALL, EBREAK, and any unrecognised opcode/funct: enter HALT from EXEC, without retiring and without changing PC.
- minstret increments in the same cycle as retire, so a later CSR read observes it.
- A reset asserted mid-instruction aborts the instruction immediately; no partial register write or store occurs after reset assertion.

Test Plan:
- Reset/first fetch: assert rst, release -> imem_rd=1 with imem_addr=0 in the first cycle; halted=0, retire=0.
- ALU chain: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SW x3,0x100(x0); EBREAK -> mem[0x100]=2; 4 retire pulses; halted=1; pc_out=0x10.
- Branch/jump: BEQ taken skips one instruction; JAL x1,+8 -> x1=PC+4. Verify via stores; a not-taken BNE falls through.
- Byte/half memory: SB 0x80 to 0x201, then LB and LBU from 0x201 -> dmem_be=4'b0010; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- CSR: CSRRS x5,mhartid,x0 with HART_ID=3 -> x5=3. CSRRW to minstret, then read it -> the write is ignored and the read value equals the retired count. mcycle read is monotonic and ≥ 3×retired.
- Illegal opcode 0xFFFFFFFF -> halted=1 and no retire; asserting rst while halted returns to FETCH at RESET_PC.

Source files
------------

// File: rtl/pito_rv32_mc_core.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC[/MEM[/LOADWB]] per instruction,
// with a read-only CSR set (cycle, instret, mhartid).
module pito_rv32_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HART_ID  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_LOADWB, S_HALT
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] rf_q [32];
  logic [31:0] mcycle_q;
  logic [31:0] minstret_q;
  logic        retire_q;
  logic        halted_q;
  logic        dmem_rd_q;
  logic        dmem_wr_q;
  logic [3:0]  dmem_be_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [1:0]  addr_lo_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] eff_addr;
  logic [31:0] npc_d;
  logic [31:0] wb_d;
  logic        wb_en;
  logic        mem_op;
  logic        is_store;
  logic        illegal;
  logic        taken;
  logic [31:0] csr_rdata;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic [31:0] ld_d;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign rd_idx   = instr_q[11:7];
  assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                     instr_q[11:8], 1'b0};
  assign imm_u    = {instr_q[31:12], 12'd0};
  assign imm_j    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                     instr_q[30:21], 1'b0};
  assign is_store = (opcode == OP_STORE);
  assign eff_addr = rs1_q + (is_store ? imm_s : imm_i);

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    case (instr_q[31:20])
      12'hB00, 12'hC00: csr_rdata = mcycle_q;
      12'hB02, 12'hC02: csr_rdata = minstret_q;
      12'hF14:          csr_rdata = HART_ID;
      default:          csr_rdata = '0;
    endcase
  end

  always_comb begin
    npc_d   = pc_q + 32'd4;
    wb_d    = '0;
    wb_en   = 1'b0;
    mem_op  = 1'b0;
    illegal = 1'b0;
    taken   = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_d = imm_u;         wb_en = 1'b1; end
      OP_AUIPC: begin wb_d = pc_q + imm_u;  wb_en = 1'b1; end
      OP_JAL: begin
        wb_d  = pc_q + 32'd4;
        wb_en = 1'b1;
        npc_d = pc_q + imm_j;
      end
      OP_JALR: begin
        illegal = (funct3 != 3'b000);
        wb_d    = pc_q + 32'd4;
        wb_en   = 1'b1;
        npc_d   = (rs1_q + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  taken = (rs1_q == rs2_q);
          3'b001:  taken = (rs1_q != rs2_q);
          3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
          3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
          3'b110:  taken = (rs1_q <  rs2_q);
          3'b111:  taken = (rs1_q >= rs2_q);
          default: illegal = 1'b1;
        endcase
        if (taken) npc_d = pc_q + imm_b;
      end
      OP_LOAD: begin
        mem_op  = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        mem_op  = 1'b1;
        illegal = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_IMM: begin
        illegal = ((funct3 == 3'b001) && (funct7 != 7'd0)) ||
                  ((funct3 == 3'b101) && ({funct7[6], funct7[4:0]} != 6'd0));
        wb_d    = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_q, imm_i);
        wb_en   = 1'b1;
      end
      OP_REG: begin
        illegal = ({funct7[6], funct7[4:0]} != 6'd0) ||
                  (funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101));
        wb_d    = alu(funct3, funct7[5], rs1_q, rs2_q);
        wb_en   = 1'b1;
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        // funct3 000 covers ECALL/EBREAK, which stop the core
        illegal = (funct3 == 3'b000) || (funct3 == 3'b100);
        wb_d    = csr_rdata;
        wb_en   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << eff_addr[1:0];
        st_data = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        st_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = rs2_q;
      end
    endcase
  end

  // Halfwords at odd addresses take the two bytes above the offset, no trap.
  assign ld_shift = dmem_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  ld_d = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_d = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_d = {24'd0, ld_shift[7:0]};
      3'b101:  ld_d = {16'd0, ld_shift[15:0]};
      default: ld_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      dmem_rd_q    <= 1'b0;
      dmem_wr_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      addr_lo_q    <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      mcycle_q  <= mcycle_q + 32'd1;
      retire_q  <= 1'b0;
      dmem_rd_q <= 1'b0;
      dmem_wr_q <= 1'b0;
      dmem_be_q <= '0;
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          instr_q <= imem_rdata;
          rs1_q   <= rf_q[imem_rdata[19:15]];
          rs2_q   <= rf_q[imem_rdata[24:20]];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (illegal) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (mem_op) begin
            dmem_addr_q <= {eff_addr[31:2], 2'b00};
            addr_lo_q   <= eff_addr[1:0];
            if (is_store) begin
              dmem_wr_q    <= 1'b1;
              dmem_be_q    <= st_be;
              dmem_wdata_q <= st_data;
            end else begin
              dmem_rd_q <= 1'b1;
            end
            state_q <= S_MEM;
          end else begin
            if (wb_en && (rd_idx != 5'd0)) rf_q[rd_idx] <= wb_d;
            pc_q       <= npc_d;
            retire_q   <= 1'b1;
            minstret_q <= minstret_q + 32'd1;
            state_q    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (is_store) begin
            pc_q       <= pc_q + 32'd4;
            retire_q   <= 1'b1;
            minstret_q <= minstret_q + 32'd1;
            state_q    <= S_FETCH;
          end else begin
            state_q <= S_LOADWB;
          end
        end
        S_LOADWB: begin
          if (rd_idx != 5'd0) rf_q[rd_idx] <= ld_d;
          pc_q       <= pc_q + 32'd4;
          retire_q   <= 1'b1;
          minstret_q <= minstret_q + 32'd1;
          state_q    <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Fetch strobe decodes the registered state so the first post-reset cycle fetches.
  assign imem_rd    = (state_q == S_FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_rd    = dmem_rd_q;
  assign dmem_wr    = dmem_wr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign retire     = retire_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_pito_rv32_mc_core.sv
// Bench for pito_rv32_mc_core: directed and random programs compared against
// an instruction-level model that also predicts cycle counts from latencies.
module tb_pito_rv32_mc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
  logic        imem_rd, dmem_rd, dmem_wr, retire, halted;
  logic [3:0]  dmem_be;

  pito_rv32_mc_core #(.RESET_PC(32'h0000_0000), .HART_ID(32'd3)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem   [1024];
  logic [31:0] img   [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] m_x   [32];
  logic [31:0] m_pc;
  int          m_ret, m_cyc;
  logic        load_req;
  logic [31:0] prog[$];
  int          total, bad;
  int          last_cyc, last_rets;
  logic [3:0]  last_be;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    end else begin
      if (imem_rd) imem_rdata <= mem[imem_addr[11:2]];
      if (dmem_rd) dmem_rdata <= mem[dmem_addr[11:2]];
      if (dmem_wr)
        for (int b = 0; b < 4; b++)
          if (dmem_be[b]) mem[dmem_addr[11:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [31:0] imm;
    int          pick;
    rd  = 5'($urandom_range(0, 31));
    r1  = 5'($urandom_range(0, 31));
    r2  = 5'($urandom_range(0, 31));
    imm = $urandom;
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0, 1, 2: begin
        if (f3 == 3'd1) imm = {27'd0, imm[4:0]};
        else if (f3 == 3'd5) imm = {20'd0, imm[10] ? 7'h20 : 7'h00, imm[4:0]};
        return enc_i(imm, r1, f3, rd, 7'h13);
      end
      3, 4: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00, r2, r1, f3, rd);
      5: return {imm[31:12], rd, imm[0] ? 7'h37 : 7'h17};
      6: begin
        pick = $urandom_range(0, 4);
        f3 = 3'((pick < 3) ? pick : pick + 1);
        return enc_i(32'h400 + $urandom_range(0, 32'h37F), 5'd0, f3, rd, 7'h03);
      end
      7: return enc_s(32'h400 + $urandom_range(0, 32'h37F), r2, 5'd0, 3'($urandom_range(0, 2)));
      8: begin
        pick = $urandom_range(0, 5);
        f3 = 3'((pick < 2) ? pick : pick + 2);
        return enc_b(4 * $urandom_range(1, 4), r2, r1, f3);
      end
      9: return enc_j(4 * $urandom_range(1, 4), rd);
      default: begin
        pick = $urandom_range(0, 5);
        f3 = 3'((pick < 3) ? pick + 1 : pick + 2);
        case ($urandom_range(0, 5))
          0: imm = 32'hB00;  1: imm = 32'hC00;  2: imm = 32'hB02;
          3: imm = 32'hC02;  4: imm = 32'hF14;  default: imm = 32'h7C0;
        endcase
        return enc_i(imm, r1, f3, rd, 7'h73);
      end
    endcase
  endfunction

  function automatic logic [31:0] m_alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    int unsigned sh = b[4:0];
    case (f3)
      0: return alt ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Architectural model: one instruction per step, cycle count from per-class latency.
  task automatic run_model();
    logic [31:0] ins, a, b, iI, iS, iB, iJ, iU, res, addr, w, nxt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, ill, tk;
    int          lat, idx;
    m_pc = 32'h0; m_ret = 0; m_cyc = 0;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int step = 0; step < 4000; step++) begin
      ins = m_mem[m_pc[11:2]];
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
      a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
      iI = {{20{ins[31]}}, ins[31:20]};
      iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      iU = {ins[31:12], 12'd0};
      nxt = m_pc + 4; res = 0; wr = 0; ill = 0; lat = 3; tk = 0;
      case (op)
        7'h37: begin res = iU; wr = 1; end
        7'h17: begin res = m_pc + iU; wr = 1; end
        7'h6F: begin res = m_pc + 4; wr = 1; nxt = m_pc + iJ; end
        7'h67: begin res = m_pc + 4; wr = 1; nxt = (a + iI) & ~32'd1; end
        7'h63: begin
          case (f3)
            0: tk = (a == b);
            1: tk = (a != b);
            4: tk = ($signed(a) <  $signed(b));
            5: tk = ($signed(a) >= $signed(b));
            6: tk = (a <  b);
            7: tk = (a >= b);
            default: ill = 1;
          endcase
          if (tk) nxt = m_pc + iB;
        end
        7'h03: begin
          addr = a + iI; idx = int'(addr[11:2]);
          w = m_mem[idx] >> (8 * addr[1:0]);
          case (f3)
            0: res = {{24{w[7]}}, w[7:0]};
            1: res = {{16{w[15]}}, w[15:0]};
            4: res = {24'd0, w[7:0]};
            5: res = {16'd0, w[15:0]};
            default: res = m_mem[idx];
          endcase
          wr = 1; lat = 5;
        end
        7'h23: begin
          addr = a + iS; idx = int'(addr[11:2]);
          case (f3)
            0: m_mem[idx][8 * addr[1:0] +: 8] = b[7:0];
            1: m_mem[idx][16 * addr[1] +: 16] = b[15:0];
            default: m_mem[idx] = b;
          endcase
          lat = 4;
        end
        7'h13: begin res = m_alu(f3, (f3 == 5) && ins[30], a, iI); wr = 1; end
        7'h33: begin res = m_alu(f3, ins[30], a, b); wr = 1; end
        7'h0F: ;
        7'h73: begin
          if (f3 == 0 || f3 == 4) ill = 1;
          case (ins[31:20])
            12'hB00, 12'hC00: res = 32'(m_cyc + 2);
            12'hB02, 12'hC02: res = 32'(m_ret);
            12'hF14:          res = 32'd3;
            default:          res = 32'd0;
          endcase
          wr = 1;
        end
        default: ill = 1;
      endcase
      if (ill) return;
      if (wr && rd != 0) m_x[rd] = res;
      m_pc = nxt; m_ret++; m_cyc += lat;
    end
  endtask

  task automatic prep();
    for (int i = 0; i < 1024; i++) img[i] = '0;
    for (int i = 256; i < 480; i++) img[i] = $urandom;
    foreach (prog[i]) img[i] = prog[i];
    m_mem = img;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; load_req = 1'b1;
    @(posedge clk); #1; load_req = 1'b0;
    @(negedge clk);
    chk({name, "_rst_imem_rd"}, imem_rd, 0);
    chk({name, "_rst_be"}, dmem_be, 0);
    rst = 1'b0; #1;
    chk({name, "_first_rd"}, imem_rd, 1);
    chk({name, "_first_addr"}, imem_addr, 32'h0);
    chk({name, "_first_halted"}, halted, 0);
    chk({name, "_first_retire"}, retire, 0);
  endtask

  task automatic run_prog(input string name);
    int  nmis, extra;
    bit  seen;
    prep();
    do_reset(name);
    run_model();
    last_cyc = 0; last_rets = 0; last_be = '0; seen = 0;
    while (halted !== 1'b1 && last_cyc < 4000) begin
      @(negedge clk); last_cyc++;
      if (retire === 1'b1) last_rets++;
      if (dmem_wr === 1'b1 && !seen) begin last_be = dmem_be; seen = 1; end
    end
    chk({name, "_halted"}, halted, 1);
    extra = 0;
    repeat (4) begin @(negedge clk); if (retire !== 1'b0) extra++; end
    chk({name, "_no_retire_after_halt"}, extra, 0);
    chk({name, "_pc"}, pc_out, m_pc);
    chk({name, "_retires"}, last_rets, m_ret);
    chk({name, "_halt_cycle"}, last_cyc, m_cyc + 3);
    for (int i = 1; i < 32; i++) chk($sformatf("%s_dump_x%0d", name, i), mem[480 + i], m_mem[480 + i]);
    nmis = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== m_mem[i]) nmis++;
    chk({name, "_mem_words_differing"}, nmis, 0);
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; total = 0; bad = 0;

    prog = '{enc_i(5, 0, 0, 1, 7'h13), enc_i(32'hFFFF_FFFD, 0, 0, 2, 7'h13),
             enc_r(0, 2, 1, 0, 3), enc_s(32'h100, 3, 0, 2), EBREAK};
    run_prog("alu");
    chk("alu_mem100", mem[64], 32'd2);
    chk("alu_retire_count", last_rets, 4);
    chk("alu_pc_out", pc_out, 32'h10);
    chk("alu_latency", last_cyc, 16);

    prog = '{enc_i(1, 0, 0, 1, 7'h13), enc_b(8, 0, 0, 0), enc_i(99, 0, 0, 1, 7'h13),
             enc_j(8, 2), enc_i(77, 0, 0, 1, 7'h13), enc_b(8, 0, 0, 1),
             enc_i(42, 0, 0, 3, 7'h13), enc_s(32'h100, 1, 0, 2), enc_s(32'h104, 2, 0, 2),
             enc_s(32'h108, 3, 0, 2), EBREAK};
    run_prog("branch");
    chk("beq_skip", mem[64], 32'd1);
    chk("jal_link", mem[65], 32'h10);
    chk("bne_fallthrough", mem[66], 32'd42);

    prog = '{enc_i(32'h80, 0, 0, 1, 7'h13), enc_s(32'h201, 1, 0, 0),
             enc_i(32'h201, 0, 0, 2, 7'h03), enc_i(32'h201, 0, 4, 3, 7'h03),
             enc_s(32'h104, 2, 0, 2), enc_s(32'h108, 3, 0, 2), EBREAK};
    run_prog("byte");
    chk("sb_be", last_be, 4'b0010);
    chk("sb_word", mem[128], 32'h0000_8000);
    chk("lb_sign", mem[65], 32'hFFFF_FF80);
    chk("lbu_zero", mem[66], 32'h0000_0080);

    prog = '{enc_i(32'hF14, 0, 2, 5, 7'h73), enc_i(100, 0, 0, 1, 7'h13),
             enc_i(32'hB02, 1, 1, 0, 7'h73), enc_i(32'hB02, 0, 2, 6, 7'h73),
             enc_i(32'hB00, 0, 2, 7, 7'h73), enc_i(32'hB00, 0, 2, 8, 7'h73),
             enc_s(32'h100, 5, 0, 2), enc_s(32'h104, 6, 0, 2),
             enc_s(32'h108, 7, 0, 2), enc_s(32'h10C, 8, 0, 2), EBREAK};
    run_prog("csr");
    chk("mhartid", mem[64], 32'd3);
    chk("minstret_ro", mem[65], 32'd3);
    chk("mcycle_a", mem[66], 32'd14);
    chk("mcycle_b", mem[67], 32'd17);

    prog = '{32'hFFFF_FFFF};
    run_prog("illegal");
    chk("illegal_no_retire", last_rets, 0);
    chk("illegal_pc", pc_out, 32'h0);
    rst = 1'b1; #1;
    chk("halt_cleared_by_rst", halted, 0);

    prog = '{enc_i(7, 0, 0, 1, 7'h13), enc_s(32'h100, 1, 0, 2), EBREAK};
    prep();
    img[64] = 32'h5555_5555;
    do_reset("abort");
    for (int n = 0; n < 20 && dmem_wr !== 1'b1; n++) @(negedge clk);
    chk("abort_store_reached", dmem_wr, 1);
    rst = 1'b1; #1;
    chk("abort_wr_dropped", dmem_wr, 0);
    @(posedge clk); #1;
    chk("abort_mem_untouched", mem[64], 32'h5555_5555);
    chk("abort_no_retire", retire, 0);

    for (int p = 0; p < 6; p++) begin
      prog.delete();
      for (int k = 0; k < 30; k++) prog.push_back(rand_instr());
      for (int r = 1; r < 32; r++) prog.push_back(enc_s(32'h780 + 4 * r, 5'(r), 0, 2));
      prog.push_back(EBREAK);
      run_prog($sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
